// File: rtl/bus_slot_arbiter.sv
// rtl/bus_slot_arbiter.sv - bus-cycle slot sequencer with DMA slot arbiter, /DTACK generator and address masking
module bus_slot_arbiter #(
    parameter int SLOT_BITS  = 2,
    parameter int ADDR_W     = 22,
    parameter int NUM_CH     = 3,
    parameter int DTACK_SLOT = 2,
    parameter int RAM_WAIT   = 0
) (
    input  logic                     clk8,
    input  logic                     _reset,
    output logic [SLOT_BITS-1:0]     busSlot,
    input  logic [ADDR_W-1:0]        cpuAddr,
    input  logic                     _cpuAS,
    input  logic                     _cpuRW,
    input  logic                     _cpuUDS,
    input  logic                     _cpuLDS,
    input  logic                     selectRAM,
    input  logic                     selectROM,
    output logic                     _cpuDTACK,
    input  logic [NUM_CH-1:0]        dmaReq,
    input  logic [NUM_CH*ADDR_W-1:0] dmaAddr,
    input  logic [NUM_CH-1:0]        dmaRom,
    output logic [NUM_CH-1:0]        dmaAck,
    input  logic [ADDR_W-1:0]        ramMask,
    input  logic [ADDR_W-1:0]        romMask,
    input  logic [ADDR_W-1:0]        romBase,
    output logic [ADDR_W-1:0]        memoryAddr,
    output logic                     _ramCS,
    output logic                     _ramOE,
    output logic                     _ramWE,
    output logic                     _romCS,
    output logic                     _romOE,
    output logic                     _memoryUDS,
    output logic                     _memoryLDS,
    output logic                     cpuOwnsBus
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} dtackState_t;

    dtackState_t           state;
    logic [1:0]            waitCnt;
    logic [SLOT_BITS-1:0]  nextSlot;
    logic                  enterDma;
    logic                  enterDtack;
    logic                  dmaHit;
    logic [NUM_CH-1:0]     dmaGrant;
    logic [ADDR_W-1:0]     dmaSelAddr;
    logic                  dmaSelRom;

    // Everything is decided on the edge that enters a slot, so decode the slot being entered.
    assign nextSlot   = busSlot + SLOT_BITS'(1);
    assign enterDma   = (nextSlot == '0);
    assign enterDtack = (nextSlot == SLOT_BITS'(DTACK_SLOT));

    function automatic logic [ADDR_W-1:0] maskAddr(input logic [ADDR_W-1:0] a, input logic toRom);
        return toRom ? ((a & romMask) | romBase) : (a & ramMask);
    endfunction

    // Scan from the highest index down so the lowest requesting channel overwrites the rest.
    always_comb begin
        dmaHit     = 1'b0;
        dmaGrant   = '0;
        dmaSelAddr = '0;
        dmaSelRom  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (dmaReq[i]) begin
                dmaHit      = 1'b1;
                dmaGrant    = '0;
                dmaGrant[i] = 1'b1;
                dmaSelAddr  = dmaAddr[i*ADDR_W +: ADDR_W];
                dmaSelRom   = dmaRom[i];
            end
        end
    end

    always_ff @(posedge clk8) begin
        if (!_reset) begin
            busSlot    <= '0;
            cpuOwnsBus <= 1'b0;
            dmaAck     <= '0;
            memoryAddr <= '0;
            _ramCS     <= 1'b1;
            _ramOE     <= 1'b1;
            _ramWE     <= 1'b1;
            _romCS     <= 1'b1;
            _romOE     <= 1'b1;
            _memoryUDS <= 1'b1;
            _memoryLDS <= 1'b1;
        end else begin
            busSlot    <= nextSlot;
            cpuOwnsBus <= !enterDma;
            dmaAck     <= '0;
            _ramCS     <= 1'b1;
            _ramOE     <= 1'b1;
            _ramWE     <= 1'b1;
            _romCS     <= 1'b1;
            _romOE     <= 1'b1;
            _memoryUDS <= 1'b1;
            _memoryLDS <= 1'b1;
            if (enterDma) begin
                // A CPU cycle still pending here gets no strobes; only DMA owns slot 0.
                if (dmaHit) begin
                    dmaAck     <= dmaGrant;
                    memoryAddr <= maskAddr(dmaSelAddr, dmaSelRom);
                    _memoryUDS <= 1'b0;
                    _memoryLDS <= 1'b0;
                    if (dmaSelRom) begin
                        _romCS <= 1'b0;
                        _romOE <= 1'b0;
                    end else begin
                        _ramCS <= 1'b0;
                        _ramOE <= 1'b0;
                    end
                end
            end else if (!_cpuAS) begin
                if (selectRAM) begin
                    memoryAddr <= maskAddr(cpuAddr, 1'b0);
                    _ramCS     <= 1'b0;
                    _ramOE     <= !_cpuRW;
                    _ramWE     <= _cpuRW;
                    _memoryUDS <= _cpuUDS;
                    _memoryLDS <= _cpuLDS;
                end else if (selectROM) begin
                    memoryAddr <= maskAddr(cpuAddr, 1'b1);
                    _romCS     <= 1'b0;
                    _romOE     <= !_cpuRW;
                    _memoryUDS <= _cpuUDS;
                    _memoryLDS <= _cpuLDS;
                end
            end
        end
    end

    // /DTACK stays low for as long as /AS does, whatever slot the bus is in.
    always_ff @(posedge clk8) begin
        if (!_reset) begin
            state     <= IDLE;
            waitCnt   <= 2'd0;
            _cpuDTACK <= 1'b1;
        end else if (_cpuAS) begin
            state     <= IDLE;
            waitCnt   <= 2'd0;
            _cpuDTACK <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (enterDtack) begin
                        if (selectRAM && RAM_WAIT != 0) begin
                            state   <= WAIT;
                            waitCnt <= RAM_WAIT[1:0];
                        end else begin
                            state     <= ACK;
                            _cpuDTACK <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (enterDtack) begin
                        waitCnt <= waitCnt - 2'd1;
                        if (waitCnt == 2'd1) begin
                            state     <= ACK;
                            _cpuDTACK <= 1'b0;
                        end
                    end
                end
                ACK: begin
                    _cpuDTACK <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    _cpuDTACK <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_slot_arbiter.sv
// tb/tb_bus_slot_arbiter.sv - scoreboard bench for bus_slot_arbiter (instances with RAM_WAIT=1 and RAM_WAIT=2)
module tb_bus_slot_arbiter;

    localparam int AW = 22;
    localparam int BUSSLOT = 0, DTACK = 1, DMAACK = 2, MADDR = 3, RAMCS = 4, RAMOE = 5;
    localparam int RAMWE = 6, ROMCS = 7, ROMOE = 8, UDS = 9, LDS = 10, OWN = 11;

    logic          clk8 = 1'b0;
    logic          _reset;
    logic [AW-1:0] cpuAddr;
    logic          _cpuAS, _cpuRW, _cpuUDS, _cpuLDS, selectRAM, selectROM;
    logic [2:0]    dmaReq, dmaRom;
    logic [3*AW-1:0] dmaAddr;
    logic [AW-1:0] ramMask, romMask, romBase;

    logic [1:0]    busSlot, busSlot2;
    logic          _cpuDTACK, _cpuDTACK2;
    logic [2:0]    dmaAck, dmaAck2;
    logic [AW-1:0] memoryAddr, memoryAddr2;
    logic          _ramCS, _ramOE, _ramWE, _romCS, _romOE, _memoryUDS, _memoryLDS, cpuOwnsBus;
    logic          _ramCS2, _ramOE2, _ramWE2, _romCS2, _romOE2, _memoryUDS2, _memoryLDS2, cpuOwnsBus2;

    bus_slot_arbiter #(.SLOT_BITS(2), .ADDR_W(AW), .NUM_CH(3), .DTACK_SLOT(2), .RAM_WAIT(1)) dut (
        .clk8(clk8), ._reset(_reset), .busSlot(busSlot), .cpuAddr(cpuAddr),
        ._cpuAS(_cpuAS), ._cpuRW(_cpuRW), ._cpuUDS(_cpuUDS), ._cpuLDS(_cpuLDS),
        .selectRAM(selectRAM), .selectROM(selectROM), ._cpuDTACK(_cpuDTACK),
        .dmaReq(dmaReq), .dmaAddr(dmaAddr), .dmaRom(dmaRom), .dmaAck(dmaAck),
        .ramMask(ramMask), .romMask(romMask), .romBase(romBase), .memoryAddr(memoryAddr),
        ._ramCS(_ramCS), ._ramOE(_ramOE), ._ramWE(_ramWE), ._romCS(_romCS), ._romOE(_romOE),
        ._memoryUDS(_memoryUDS), ._memoryLDS(_memoryLDS), .cpuOwnsBus(cpuOwnsBus)
    );

    bus_slot_arbiter #(.SLOT_BITS(2), .ADDR_W(AW), .NUM_CH(3), .DTACK_SLOT(2), .RAM_WAIT(2)) dut2 (
        .clk8(clk8), ._reset(_reset), .busSlot(busSlot2), .cpuAddr(cpuAddr),
        ._cpuAS(_cpuAS), ._cpuRW(_cpuRW), ._cpuUDS(_cpuUDS), ._cpuLDS(_cpuLDS),
        .selectRAM(selectRAM), .selectROM(selectROM), ._cpuDTACK(_cpuDTACK2),
        .dmaReq(dmaReq), .dmaAddr(dmaAddr), .dmaRom(dmaRom), .dmaAck(dmaAck2),
        .ramMask(ramMask), .romMask(romMask), .romBase(romBase), .memoryAddr(memoryAddr2),
        ._ramCS(_ramCS2), ._ramOE(_ramOE2), ._ramWE(_ramWE2), ._romCS(_romCS2), ._romOE(_romOE2),
        ._memoryUDS(_memoryUDS2), ._memoryLDS(_memoryLDS2), .cpuOwnsBus(cpuOwnsBus2)
    );

    always #5 clk8 = ~clk8;

    typedef struct { int cyc; int id; logic [31:0] val; } expEntry_t;
    typedef struct { logic [2:0] ack; logic [AW-1:0] addr; } ackEntry_t;

    expEntry_t expQ[$];
    ackEntry_t ackQ[$];
    ackEntry_t ae;
    int        dtackQ[$], dtackQ2[$];
    int        checks = 0, errors = 0;
    int        cyc = 0, c0, want;
    logic [1:0] mSlot = 2'd0;
    logic      dPrev = 1'b1, dPrev2 = 1'b1;

    always @(posedge clk8) begin
        cyc   <= cyc + 1;
        mSlot <= (!_reset) ? 2'd0 : mSlot + 2'd1;
    end

    function automatic logic [31:0] sigVal(input int id);
        logic [31:0] v;
        case (id)
            0:  v = 32'(busSlot);     16: v = 32'(busSlot2);
            1:  v = 32'(_cpuDTACK);   17: v = 32'(_cpuDTACK2);
            2:  v = 32'(dmaAck);      18: v = 32'(dmaAck2);
            3:  v = 32'(memoryAddr);  19: v = 32'(memoryAddr2);
            4:  v = 32'(_ramCS);      20: v = 32'(_ramCS2);
            5:  v = 32'(_ramOE);      21: v = 32'(_ramOE2);
            6:  v = 32'(_ramWE);      22: v = 32'(_ramWE2);
            7:  v = 32'(_romCS);      23: v = 32'(_romCS2);
            8:  v = 32'(_romOE);      24: v = 32'(_romOE2);
            9:  v = 32'(_memoryUDS);  25: v = 32'(_memoryUDS2);
            10: v = 32'(_memoryLDS);  26: v = 32'(_memoryLDS2);
            11: v = 32'(cpuOwnsBus);  27: v = 32'(cpuOwnsBus2);
            default: v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    function automatic string sigName(input int id);
        string b;
        case (id % 16)
            0: b = "busSlot";   1: b = "_cpuDTACK"; 2: b = "dmaAck";  3: b = "memoryAddr";
            4: b = "_ramCS";    5: b = "_ramOE";    6: b = "_ramWE";  7: b = "_romCS";
            8: b = "_romOE";    9: b = "_memoryUDS"; 10: b = "_memoryLDS"; default: b = "cpuOwnsBus";
        endcase
        return (id >= 16) ? {b, "#2"} : b;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic expBoth(input int k, input int id, input logic [31:0] v);
        expQ.push_back('{cyc + k, id, v});
        expQ.push_back('{cyc + k, id + 16, v});
    endtask

    task automatic expOne(input int k, input int id, input logic [31:0] v);
        expQ.push_back('{cyc + k, id, v});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk8);
    endtask

    task automatic toSlot(input logic [1:0] s);
        @(negedge clk8);
        while (mSlot != s) @(negedge clk8);
    endtask

    // Monitor: time-keyed expectations, ack pulses and /DTACK falling edges.
    always @(negedge clk8) begin
        check("busSlot", 32'(busSlot), 32'(mSlot));
        check("busSlot#2", 32'(busSlot2), 32'(mSlot));
        for (int i = expQ.size() - 1; i >= 0; i--) begin
            if (expQ[i].cyc == cyc) begin
                check(sigName(expQ[i].id), sigVal(expQ[i].id), expQ[i].val);
                expQ.delete(i);
            end
        end
        if (dmaAck !== 3'b000 || dmaAck2 !== 3'b000) begin
            if (ackQ.size() == 0) begin
                checks++; errors++;
                $display("FAIL dmaAck @cyc %0d: got %b/%b, expected 000", cyc, dmaAck, dmaAck2);
            end else begin
                ae = ackQ.pop_front();
                check("dmaAck", 32'(dmaAck), 32'(ae.ack));
                check("dmaAck#2", 32'(dmaAck2), 32'(ae.ack));
                check("dmaAddr", 32'(memoryAddr), 32'(ae.addr));
                check("dmaAddr#2", 32'(memoryAddr2), 32'(ae.addr));
                check("ackSlot", 32'(busSlot), 32'd0);
            end
        end
        if (dPrev && !_cpuDTACK) begin
            if (dtackQ.size() == 0) begin
                checks++; errors++;
                $display("FAIL dtack @cyc %0d: got assertion, expected none", cyc);
            end else begin
                want = dtackQ.pop_front();
                check("dtackCycle", 32'(cyc), 32'(want));
            end
        end
        if (dPrev2 && !_cpuDTACK2) begin
            if (dtackQ2.size() == 0) begin
                checks++; errors++;
                $display("FAIL dtack#2 @cyc %0d: got assertion, expected none", cyc);
            end else begin
                want = dtackQ2.pop_front();
                check("dtackCycle#2", 32'(cyc), 32'(want));
            end
        end
        dPrev  <= _cpuDTACK;
        dPrev2 <= _cpuDTACK2;
    end

    initial begin
        ramMask = 22'h07FFFF; romMask = 22'h00FFFF; romBase = 22'h020000;
        dmaAddr = {22'h3C0FFE, 22'h2ABCDE, 22'h123456};
        dmaRom  = 3'b100;
        cpuAddr = '0; _cpuUDS = 1'b0; _cpuLDS = 1'b0; selectROM = 1'b0;
        // Reset held with every request active.
        _reset = 1'b0; dmaReq = 3'b111; _cpuAS = 1'b0; selectRAM = 1'b1; _cpuRW = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            expBoth(k, DTACK, 1); expBoth(k, DMAACK, 0); expBoth(k, RAMCS, 1);
            expBoth(k, ROMCS, 1); expBoth(k, RAMWE, 1);
        end
        expBoth(3, BUSSLOT, 0); expBoth(4, BUSSLOT, 1);
        tick(3);
        _reset = 1'b1; dmaReq = 3'b000; _cpuAS = 1'b1; selectRAM = 1'b0; _cpuRW = 1'b1;
        _cpuUDS = 1'b1; _cpuLDS = 1'b1;

        // Priority: ch1 beats ch2 (RAM), then ch2 alone (ROM), then no request holds address.
        toSlot(3);
        dmaReq = 3'b110;
        ackQ.push_back('{3'b010, 22'h02BCDE});
        expBoth(1, RAMCS, 0); expBoth(1, RAMOE, 0); expBoth(1, RAMWE, 1); expBoth(1, ROMCS, 1);
        expBoth(1, UDS, 0); expBoth(1, LDS, 0); expBoth(1, OWN, 0); expBoth(2, OWN, 1); expBoth(2, RAMCS, 1);
        tick(1); dmaReq = 3'b100;
        toSlot(3);
        ackQ.push_back('{3'b100, 22'h020FFE});
        expBoth(1, ROMCS, 0); expBoth(1, ROMOE, 0); expBoth(1, RAMCS, 1); expBoth(1, RAMWE, 1);
        tick(1); dmaReq = 3'b000;
        toSlot(3);
        expBoth(1, MADDR, 22'h020FFE); expBoth(1, ROMCS, 1); expBoth(1, RAMCS, 1); expBoth(1, DMAACK, 0);

        // ROM read with masking, /DTACK held across slot 0 until /AS negates in slot 1.
        toSlot(0);
        cpuAddr = 22'h41ABCD; selectROM = 1'b1; _cpuRW = 1'b1; _cpuAS = 1'b0; _cpuUDS = 1'b0; _cpuLDS = 1'b1;
        expBoth(1, MADDR, 22'h02ABCD); expBoth(1, ROMCS, 0); expBoth(1, ROMOE, 0); expBoth(1, RAMCS, 1);
        expBoth(1, RAMWE, 1); expBoth(1, UDS, 0); expBoth(1, LDS, 1); expBoth(1, DTACK, 1);
        dtackQ.push_back(cyc + 2); dtackQ2.push_back(cyc + 2);
        expBoth(4, ROMCS, 1); expBoth(4, UDS, 1); expBoth(4, DTACK, 0); expBoth(5, DTACK, 0); expBoth(5, ROMCS, 0);
        tick(5);
        _cpuAS = 1'b1; selectROM = 1'b0;
        expBoth(1, DTACK, 1);

        // RAM write with wait cycles; a DMA grant lands in the intervening slot 0.
        toSlot(0);
        c0 = cyc;
        cpuAddr = 22'h1F0042; selectRAM = 1'b1; _cpuRW = 1'b0; _cpuAS = 1'b0; _cpuUDS = 1'b0; _cpuLDS = 1'b0;
        expBoth(1, MADDR, 22'h070042); expBoth(1, RAMCS, 0); expBoth(1, RAMOE, 1); expBoth(1, RAMWE, 0);
        expBoth(2, RAMWE, 0); expBoth(3, RAMWE, 0); expBoth(5, RAMWE, 0); expBoth(5, MADDR, 22'h070042);
        dtackQ.push_back(c0 + 6); dtackQ2.push_back(c0 + 10);
        expOne(5, DTACK, 1); expOne(9, DTACK, 0); expOne(9, DTACK + 16, 1);
        tick(3);
        dmaReq = 3'b001;
        ackQ.push_back('{3'b001, 22'h023456});
        expBoth(1, RAMWE, 1); expBoth(1, RAMOE, 0); expBoth(1, RAMCS, 0); expBoth(1, UDS, 0);
        tick(1); dmaReq = 3'b000;
        tick(6);
        _cpuAS = 1'b1; selectRAM = 1'b0;
        expBoth(1, DTACK, 1);

        // Abort during WAIT, then a full-length retry.
        toSlot(0);
        cpuAddr = 22'h000100; selectRAM = 1'b1; _cpuRW = 1'b1; _cpuAS = 1'b0;
        expBoth(1, RAMOE, 0); expBoth(1, RAMWE, 1); expBoth(1, MADDR, 22'h000100);
        tick(3);
        _cpuAS = 1'b1; selectRAM = 1'b0;
        expBoth(3, DTACK, 1); expBoth(4, DTACK, 1);
        toSlot(0);
        selectRAM = 1'b1; _cpuAS = 1'b0;
        dtackQ.push_back(cyc + 6); dtackQ2.push_back(cyc + 10);
        tick(10);
        _cpuAS = 1'b1; selectRAM = 1'b0;
        expBoth(1, DTACK, 1);

        // Reset on the edge that would grant: grant dropped, client retries.
        toSlot(3);
        dmaReq = 3'b001; _reset = 1'b0;
        expBoth(1, DMAACK, 0); expBoth(1, RAMCS, 1); expBoth(1, BUSSLOT, 0);
        tick(1);
        _reset = 1'b1;
        ackQ.push_back('{3'b001, 22'h023456});
        toSlot(0);
        dmaReq = 3'b000;
        tick(6);

        if (expQ.size() != 0) begin
            checks++; errors++;
            $display("FAIL pending expectations: got %0d left, expected 0", expQ.size());
        end
        if (ackQ.size() != 0) begin
            checks++; errors++;
            $display("FAIL missing dmaAck: got %0d unseen, expected 0", ackQ.size());
        end
        if (dtackQ.size() != 0 || dtackQ2.size() != 0) begin
            checks++; errors++;
            $display("FAIL missing dtack: got %0d/%0d unseen, expected 0", dtackQ.size(), dtackQ2.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
